// File: rtl/cu_pkg.sv
// Shared control-unit package.
// Holds the operation, power-mode and flag types used across the CU, the
// divider FSM state type and the default datapath width.
package cu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4
  } operation_t;

  typedef enum logic [1:0] {
    PM_RUN       = 2'd0,
    PM_CLK_GATED = 2'd1,
    PM_SLEEP     = 2'd2
  } powermode_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic div_by_zero;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALCULATE = 2'd1,
    FINISH    = 2'd2
  } div_state_t;

endpackage

// File: rtl/sequential_divider_16bit_div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, tries to subtract
// the divisor and keeps the difference only when it does not go negative.
//   rem      [WIDTH:0]   partial remainder before the step
//   q_msb                dividend bit shifted in (MSB of quotient shift reg)
//   divisor  [WIDTH-1:0] divisor
//   next_rem [WIDTH:0]   partial remainder after the step
//   q_bit                quotient bit produced by this step
module div_step
  import cu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;

  // The shift keeps rem's top bit so the subtraction sign is exact for any
  // input. Since a restored remainder is always below the divisor that bit
  // is zero in operation, which makes this the plain WIDTH+1-bit trial.
  assign r_shift  = {rem, q_msb};
  assign trial    = r_shift - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  assign next_rem = q_bit ? trial[WIDTH:0] : r_shift[WIDTH:0];

endmodule

// File: rtl/sequential_divider_16bit.sv
// sequential_divider_16bit: multi-cycle unsigned restoring divider.
// One quotient bit per cycle, MSB first, behind a start/done handshake.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only while idle
//   a, b         dividend / divisor, captured on the accepting edge
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (dividend on divide-by-zero)
//   div_by_zero  registered, set with done when the divisor was 0
//   busy         high whenever the FSM is not idle
//   done         registered single-cycle completion pulse
module sequential_divider_16bit
  import cu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem_q),
    .q_msb    (q_sh_q[WIDTH-1]),
    .divisor  (div_q),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    q_sh_d      = q_sh_q;
    div_d       = div_q;
    rem_d       = rem_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_sh_d  = a;
          div_d   = b;
          rem_d   = '0;
          count_d = '0;
          // A zero divisor skips the iterations entirely.
          state_d = (b == '0) ? FINISH : CALCULATE;
        end
      end

      CALCULATE: begin
        rem_d   = step_rem;
        q_sh_d  = {q_sh_q[WIDTH-2:0], step_bit};
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) state_d = FINISH;
      end

      FINISH: begin
        if (div_q == '0) begin
          // The dividend is still untouched in the shift register.
          quotient_d  = '1;
          remainder_d = q_sh_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = q_sh_q;
          remainder_d = rem_q[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_sh_q      <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_sh_q      <= q_sh_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sequential_divider_16bit.sv
// Self-checking bench for sequential_divider_16bit. Expected results come
// from plain unsigned / and % in the bench; the step cell is checked
// against the arithmetic definition of one restoring step.
module tb_sequential_divider_16bit;
  import cu_pkg::*;

  localparam int W = DATA_W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  sequential_divider_16bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  // Standalone step cell, exercised against its arithmetic meaning.
  logic [W:0]   st_rem;
  logic         st_msb;
  logic [W-1:0] st_div;
  logic [W:0]   st_next;
  logic         st_q;

  div_step #(.WIDTH(W)) u_step (
    .rem      (st_rem),
    .q_msb    (st_msb),
    .divisor  (st_div),
    .next_rem (st_next),
    .q_bit    (st_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts edges from the accepting edge (edge 1) until done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transaction: accept, latency, results, invariant, single-cycle done.
  task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    logic [W-1:0] eq, er;
    logic         edz;
    int           exp_lat, lat;
    if (bv == '0) begin
      eq = '1; er = av; edz = 1'b1; exp_lat = 2;
    end else begin
      eq = av / bv; er = av % bv; edz = 1'b0; exp_lat = W + 2;
    end
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check({tag, ".busy"}, busy, 1);
    wait_done(lat);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dbz"}, div_by_zero, edz);
    if (bv != '0) begin
      check({tag, ".inv"}, 64'(quotient) * 64'(bv) + 64'(remainder), 64'(av));
      check({tag, ".rlt"}, remainder < bv, 1);
    end
    @(posedge clk); #1;
    check({tag, ".pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int seen;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    st_rem = '0; st_msb = 1'b0; st_div = 16'd1;
    #22;
    check("rst.q", quotient, 0);
    check("rst.r", remainder, 0);
    check("rst.dbz", div_by_zero, 0);
    check("rst.done", done, 0);
    check("rst.busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_div(16'd100, 16'd7, "d100_7");
    do_div(16'hFFFF, 16'd1, "dffff_1");
    do_div(16'hFFFF, 16'hFFFF, "dffff_ffff");
    do_div(16'd3, 16'd10, "d3_10");
    do_div(16'd5, 16'd0, "d5_0");
    do_div(16'd9, 16'd2, "d9_2");

    // start held high with operands churning while busy, then a
    // back-to-back request issued in the done cycle.
    a = 16'd1000; b = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < 40) begin
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("hold.lat", lat, W + 2);
    check("hold.q", quotient, 333);
    check("hold.r", remainder, 1);
    a = 16'd50; b = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.busy", busy, 1);
    check("b2b.done_low", done, 0);
    check("b2b.old_q", quotient, 333);
    wait_done(lat);
    check("b2b.lat", lat, W + 2);
    check("b2b.q", quotient, 10);
    check("b2b.r", remainder, 0);
    check("b2b.dbz", div_by_zero, 0);
    @(posedge clk); #1;

    // Asynchronous reset while iterating (count reaches 7 after edge 8).
    a = 16'd60000; b = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.q", quotient, 0);
    check("arst.r", remainder, 0);
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("arst.quiet", seen, 0);
    do_div(16'd200, 16'd13, "d200_13");

    // Step cell against its arithmetic definition, rem below divisor.
    for (int i = 0; i < 24; i++) begin
      int unsigned dv, rv, s;
      logic        bit_in;
      dv = $urandom_range(1, 65535);
      rv = $urandom % dv;
      bit_in = 1'($urandom);
      st_div = W'(dv); st_rem = (W+1)'(rv); st_msb = bit_in;
      #1;
      s = 2 * rv + 32'(bit_in);
      check("step.q", st_q, (s >= dv) ? 1 : 0);
      check("step.rem", st_next, (s >= dv) ? 64'(s - dv) : 64'(s));
    end

    // Random sweep, biased towards small divisors a quarter of the time.
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] av, bv;
      av = W'($urandom);
      if ($urandom_range(0, 3) == 0) bv = W'($urandom_range(1, 15));
      else                            bv = W'($urandom_range(1, 65535));
      do_div(av, bv, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
